// File: rtl/dma_mem_responder.sv
// Memory-side responder for the DMA memory port: a wait-state FSM grants each
// request, then performs the write or read on an internal 64-bit word array.
module dma_mem_responder #(
   parameter int          DEPTH       = 64,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [63:0] BASE_ADDR   = 64'h0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mem_req,
   input  logic                      mem_we,
   input  logic [63:0]               mem_addr,
   input  logic [63:0]               mem_wdata,
   output logic                      mem_gnt,
   output logic [63:0]               mem_rdata,
   output logic                      mem_rvalid,
   output logic                      mem_err,
   output logic [15:0]               wr_count,
   input  logic [$clog2(DEPTH)-1:0]  dbg_addr,
   output logic [63:0]               dbg_rdata
);

   localparam int          AW        = $clog2(DEPTH);
   localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCEPT = 2'd2
   } state_t;

   state_t         state_r;
   state_t         state_nxt_s;
   logic [3:0]     cnt_r;
   logic [3:0]     cnt_nxt_s;
   logic           gnt_r;
   logic           rvalid_r;
   logic           err_r;
   logic [63:0]    rdata_r;
   logic [15:0]    wr_count_r;
   logic [63:0]    dbg_rdata_r;
   logic [63:0]    mem_r [DEPTH];

   logic [63:0]    offset_s;
   logic           valid_s;
   logic [AW-1:0]  index_s;
   logic           accept_s;
   logic           write_s;

   assign offset_s = mem_addr - BASE_ADDR;
   assign valid_s  = (offset_s[2:0] == 3'b000) && (offset_s[63:3] < 61'(DEPTH));
   assign index_s  = offset_s[AW+2:3];
   assign accept_s = (state_r == ACCEPT) && mem_req;
   assign write_s  = accept_s && mem_we && valid_s;

   // Next-state and wait-counter logic of the grant FSM.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (mem_req) begin
               if (WAIT_CYCLES > 0) begin
                  state_nxt_s = WAIT;
                  cnt_nxt_s   = WAIT_LOAD;
               end else begin
                  state_nxt_s = ACCEPT;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT: begin
            if (!mem_req) begin
               state_nxt_s = IDLE;
            end else if (cnt_r == 4'd0) begin
               state_nxt_s = ACCEPT;
            end else begin
               cnt_nxt_s = cnt_r - 4'd1;
            end
         end
         ACCEPT:  state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM state, registered grant, response outputs, write counter and backdoor port.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         cnt_r       <= 4'd0;
         gnt_r       <= 1'b0;
         rvalid_r    <= 1'b0;
         err_r       <= 1'b0;
         rdata_r     <= 64'h0;
         wr_count_r  <= 16'h0;
         dbg_rdata_r <= 64'h0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         gnt_r       <= (state_nxt_s == ACCEPT);
         rvalid_r    <= accept_s && !mem_we;
         err_r       <= accept_s && !valid_s;
         dbg_rdata_r <= mem_r[dbg_addr];
         if (accept_s && !valid_s) begin
            rdata_r <= 64'h0;
         end else if (accept_s && !mem_we) begin
            rdata_r <= mem_r[index_s];
         end
         if (write_s && (wr_count_r != 16'hFFFF)) begin
            wr_count_r <= wr_count_r + 16'd1;
         end
      end
   end

   // Word array; deliberately not reset so contents survive a reset.
   always_ff @(posedge clk) begin
      if (!rst && write_s) begin
         mem_r[index_s] <= mem_wdata;
      end
   end

   assign mem_gnt    = gnt_r;
   assign mem_rvalid = rvalid_r;
   assign mem_err    = err_r;
   assign mem_rdata  = rdata_r;
   assign wr_count   = wr_count_r;
   assign dbg_rdata  = dbg_rdata_r;

endmodule

// File: tb/tb_dma_mem_responder.sv
// Randomized self-checking bench for dma_mem_responder against an
// address-decoding word-array model, plus a zero-wait-state instance.
module tb_dma_mem_responder;

   localparam int          DEPTH = 64;
   localparam int          WAITS = 2;
   localparam logic [63:0] BASE  = 64'h100;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req, mem_we;
   logic [63:0] mem_addr, mem_wdata;
   logic        mem_gnt, mem_rvalid, mem_err;
   logic [63:0] mem_rdata, dbg_rdata;
   logic [15:0] wr_count;
   logic [5:0]  dbg_addr;

   logic        req0, we0, gnt0, rvalid0, err0;
   logic [63:0] addr0, wdata0, rdata0, dbg_rdata0;
   logic [15:0] wr_count0;
   logic [5:0]  dbg_addr0;

   int checks = 0;
   int errors = 0;

   logic [63:0] model_mem   [DEPTH];
   bit          model_known [DEPTH];
   int          model_cnt = 0;

   always #5 clk = ~clk;

   dma_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITS), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
      .mem_rvalid(mem_rvalid), .mem_err(mem_err), .wr_count(wr_count),
      .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata));

   dma_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(64'h0)) dut0 (
      .clk(clk), .rst(rst), .mem_req(req0), .mem_we(we0), .mem_addr(addr0),
      .mem_wdata(wdata0), .mem_gnt(gnt0), .mem_rdata(rdata0),
      .mem_rvalid(rvalid0), .mem_err(err0), .wr_count(wr_count0),
      .dbg_addr(dbg_addr0), .dbg_rdata(dbg_rdata0));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Model of a granted access: decode from the byte offset, apply the write.
   task automatic model_access(input logic we, input logic [63:0] addr, input logic [63:0] data,
                               output bit valid, output int idx);
      logic [63:0] off;
      off   = addr - BASE;
      valid = (off % 64'd8 == 64'd0) && (off / 64'd8 < 64'(DEPTH));
      idx   = valid ? int'(off / 64'd8) : 0;
      if (valid && we) begin
         model_mem[idx]   = data;
         model_known[idx] = 1'b1;
         if (model_cnt < 65535) model_cnt++;
      end
   endtask

   // One complete transaction with garbage fields while waiting.
   task automatic do_txn(input logic we, input logic [63:0] addr, input logic [63:0] data);
      int n;
      bit got, valid;
      int idx;
      logic [63:0] old;
      @(negedge clk);
      mem_req = 1'b1; mem_we = $urandom_range(0, 1); mem_addr = rnd64(); mem_wdata = rnd64();
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
         @(posedge clk); #1; n++;
         if (mem_gnt) got = 1'b1;
         else begin
            mem_we = $urandom_range(0, 1); mem_addr = rnd64(); mem_wdata = rnd64();
         end
      end
      chk("gnt_latency", 64'(n), 64'(WAITS + 1));
      if (!got) begin
         mem_req = 1'b0;
         return;
      end
      mem_we = we; mem_addr = addr; mem_wdata = data;
      @(posedge clk); #1;
      mem_req = 1'b0;
      model_access(we, addr, data, valid, idx);
      old = model_mem[idx];
      chk("rvalid", 64'(mem_rvalid), 64'(!we));
      chk("err", 64'(mem_err), 64'(!valid));
      chk("gnt_after_accept", 64'(mem_gnt), 64'd0);
      if (!valid) chk("rdata_invalid", mem_rdata, 64'h0);
      else if (!we && model_known[idx]) chk("rdata", mem_rdata, old);
      chk("wr_count", 64'(wr_count), 64'(model_cnt));
   endtask

   task automatic check_backdoor();
      for (int i = 0; i < DEPTH; i++) begin
         if (model_known[i]) begin
            @(negedge clk); dbg_addr = 6'(i);
            @(posedge clk); #1;
            chk($sformatf("backdoor[%0d]", i), dbg_rdata, model_mem[i]);
         end
      end
   endtask

   initial begin
      bit v;
      int idx, g;
      logic [63:0] a, d;
      for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;
      rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_addr = 64'h0; mem_wdata = 64'h0;
      dbg_addr = 6'd0; req0 = 1'b0; we0 = 1'b0; addr0 = 64'h0; wdata0 = 64'h0; dbg_addr0 = 6'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt", 64'(mem_gnt), 64'd0);
      chk("rst_rvalid", 64'(mem_rvalid), 64'd0);
      chk("rst_err", 64'(mem_err), 64'd0);
      chk("rst_rdata", mem_rdata, 64'h0);
      chk("rst_wr_count", 64'(wr_count), 64'd0);
      chk("rst_dbg_rdata", dbg_rdata, 64'h0);
      rst = 1'b0;

      // Burst of ten writes with the request held high throughout.
      @(negedge clk);
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = rnd64();
      g = 0;
      for (int k = 1; k <= 44; k++) begin
         @(posedge clk); #1;
         chk("burst_gnt", 64'(mem_gnt), 64'((g < 10) && (k == 3 + 4 * g)));
         if (mem_gnt) begin
            mem_we = 1'b1; mem_addr = BASE + 64'(8 * g); mem_wdata = 64'hDEAD0000 + 64'(g);
            model_access(1'b1, mem_addr, mem_wdata, v, idx);
            g++;
         end else if (g == 10) begin
            mem_req = 1'b0;
         end else begin
            mem_we = $urandom_range(0, 1); mem_addr = rnd64(); mem_wdata = rnd64();
         end
         if (k > 1) chk("burst_err", 64'(mem_err), 64'd0);
      end
      chk("burst_wr_count", 64'(wr_count), 64'd10);
      check_backdoor();

      // Read after write and invalid accesses.
      do_txn(1'b1, 64'h108, 64'h1234);
      do_txn(1'b0, 64'h108, 64'h0);
      do_txn(1'b1, 64'h104, rnd64());
      do_txn(1'b1, BASE + 64'(8 * DEPTH), rnd64());
      do_txn(1'b0, 64'h0, 64'h0);
      check_backdoor();

      // Zero wait states: request held, grants on alternate cycles.
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 64'h40; wdata0 = rnd64();
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         chk("zw_gnt", 64'(gnt0), 64'(k % 2));
      end
      req0 = 1'b0;
      @(posedge clk); #1;
      chk("zw_wr_count", 64'(wr_count0), 64'd6);

      // Random traffic, with occasional withdrawn requests.
      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 4))
            0, 1:    a = BASE + 64'(8 * $urandom_range(0, DEPTH - 1));
            2:       a = BASE + 64'(8 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 7));
            3:       a = BASE + 64'(8 * (DEPTH + $urandom_range(0, 1000)));
            default: a = rnd64();
         endcase
         d = rnd64();
         if ($urandom_range(0, 3) == 0) begin
            int w;
            w = $urandom_range(1, WAITS);
            @(negedge clk);
            mem_req = 1'b1; mem_we = 1'b1; mem_addr = a; mem_wdata = d;
            for (int k = 0; k < w; k++) begin
               @(posedge clk); #1;
               chk("withdraw_gnt", 64'(mem_gnt), 64'd0);
            end
            mem_req = 1'b0;
            @(posedge clk); #1;
            chk("withdraw_gnt_end", 64'(mem_gnt), 64'd0);
            chk("withdraw_wr_count", 64'(wr_count), 64'(model_cnt));
         end
         do_txn($urandom_range(0, 1), a, d);
      end
      check_backdoor();

      // Reset during the ACCEPT cycle of a write.
      do_txn(1'b1, BASE + 64'd160, 64'hA5A5_5A5A_0F0F_F0F0);
      @(negedge clk);
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = BASE + 64'd160; mem_wdata = 64'h1111_2222_3333_4444;
      g = 0;
      while (!mem_gnt && g < 20) begin
         @(posedge clk); #1; g++;
      end
      chk("rst_accept_latency", 64'(g), 64'(WAITS + 1));
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_accept_gnt", 64'(mem_gnt), 64'd0);
      rst = 1'b0; mem_req = 1'b0;
      model_cnt = 0;
      @(posedge clk); #1;
      chk("rst_accept_wr_count", 64'(wr_count), 64'd0);
      chk("rst_accept_gnt_idle", 64'(mem_gnt), 64'd0);
      check_backdoor();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
